// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// FSM encoding, 8N1 frame constants and default timing.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  localparam int DATA_BITS    = 8;
  localparam int STOP_BITS    = 1;
  localparam int DEF_CLK_FREQ = 12000000;
  localparam int DEF_BAUD     = 115200;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte requester bundle between N_REQ sources and the arbiter.
// Sources drive valid/data; the arbiter returns a one-hot ready.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator; phase restarts whenever en is low.
// Bit periods alternate between floor and ceil of CLK_FREQ/BAUD.
module baud_tick_gen #(
  parameter int OVERSAMPLE = 1,
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int INC = BAUD * OVERSAMPLE;

  logic [31:0] acc;
  logic [32:0] sum;

  assign sum  = {1'b0, acc} + 33'(INC);
  assign tick = en && (sum >= 33'(CLK_FREQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!en) begin
      acc <= '0;
    end else if (tick) begin
      acc <= 32'(sum - 33'(CLK_FREQ));
    end else begin
      acc <= sum[31:0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter.
// Ready is registered: offered in IDLE, transfer on valid&ready.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int N_REQ    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arbiter_if.slave         req,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);

  logic [1:0]    rsync;
  logic          rst_s_n;
  tx_state_t     state;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic [GW-1:0] offer;
  logic [GW-1:0] pick;
  logic          tick;
  logic          en;
  logic          arb;

  // Assert asynchronously, release on a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  end

  assign rst_s_n = rsync[1];

  function automatic logic [GW-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [GW-1:0]    last
  );
    logic [GW-1:0] w;
    logic          hit;
    int            idx;
    w   = last;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!hit && v[idx]) begin
        w   = GW'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  assign en   = (state != S_IDLE);
  assign pick = rr_pick(req.req_valid, grant_id);

  // Arbitrate when idle with no offer, or on the last STOP cycle
  // so the offer lands on the first IDLE cycle.
  assign arb = (|req.req_valid) &&
               ((state == S_IDLE && req.req_ready == '0) ||
                (state == S_STOP && tick));

  baud_tick_gen #(
    .OVERSAMPLE(1),
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_s_n),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state         <= S_IDLE;
      tx            <= 1'b1;
      busy          <= 1'b0;
      req.req_ready <= '0;
      grant_id      <= GW'(N_REQ - 1);
      offer         <= '0;
      shift         <= '0;
      bitcnt        <= '0;
    end else begin
      req.req_ready <= '0;
      if (arb) begin
        req.req_ready <= N_REQ'(1) << pick;
        offer         <= pick;
      end
      unique case (state)
        S_IDLE: begin
          if (|(req.req_valid & req.req_ready)) begin
            state    <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            grant_id <= offer;
            shift    <= req.req_data[int'(offer)*8 +: 8];
          end
        end
        S_START: begin
          if (tick) begin
            state  <= S_DATA;
            tx     <= shift[0];
            bitcnt <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift  <= {1'b0, shift[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'(DATA_BITS - 1)) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: queue-based requesters, tx line decoder,
// round-robin reference model over the request queues.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) ifc ();
  uart_tx_arbiter_if #(.N_REQ(4)) ifc_f ();

  logic       tx, busy, tx_f, busy_f;
  logic [1:0] gid, gid_f;

  uart_tx_arbiter #(
    .CLK_FREQ(12000000), .BAUD(115200), .N_REQ(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(ifc),
    .tx(tx), .busy(busy), .grant_id(gid)
  );

  uart_tx_arbiter #(
    .CLK_FREQ(48000000), .BAUD(1000000), .N_REQ(4)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .req(ifc_f),
    .tx(tx_f), .busy(busy_f), .grant_id(gid_f)
  );

  int checks = 0;
  int errors = 0;

  // requester queues and manual overrides
  logic [7:0] qs [4][$];
  logic [3:0] man_en = '0;
  logic [3:0] man_v  = '0;
  logic [7:0] man_d  = '0;
  logic [3:0] hs_pend = '0;

  // monitor results
  int         cyc = 0;
  int         acc_q[$];
  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         len_q[$];
  int         low_q[$];
  int         rdy_pulses = 0;
  int         rdy1_cnt = 0;
  int         proto_viol = 0;
  int         stop_err = 0;
  logic       have_fall = 1'b0;

  // reference model output
  int         exp_g[$];
  logic [7:0] exp_b[$];
  int         model_last = 3;

  real P = 12000000.0 / 115200.0;

  initial begin
    ifc_f.req_valid = '0;
    ifc_f.req_data  = '0;
  end

  // requester driver
  initial begin
    logic [31:0] d;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (hs_pend[i] && !man_en[i] && qs[i].size() > 0)
          void'(qs[i].pop_front());
      d = '0;
      for (int i = 0; i < 4; i++) begin
        if (man_en[i]) begin
          ifc.req_valid[i] = man_v[i];
          d[i*8 +: 8] = man_d;
        end else begin
          ifc.req_valid[i] = (qs[i].size() > 0);
          if (qs[i].size() > 0) d[i*8 +: 8] = qs[i][0];
        end
      end
      ifc.req_data = d;
    end
  end

  // monitor: handshakes, busy runs, tx decoding
  initial begin
    logic       prev_tx, prev_busy, in_frame, rose;
    int         st, j, rise_cyc, fall_cyc;
    logic [7:0] sh;
    prev_tx = 1'b1; prev_busy = 1'b0; in_frame = 1'b0; rose = 1'b0;
    st = 0; j = 0; rise_cyc = 0; fall_cyc = 0; sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      hs_pend = ifc.req_ready & ifc.req_valid;
      if (!rst_n) begin
        in_frame = 1'b0; prev_tx = 1'b1; prev_busy = 1'b0;
        have_fall = 1'b0;
      end else begin
        if (ifc.req_ready != '0) begin
          rdy_pulses++;
          if (ifc.req_ready[1]) rdy1_cnt++;
          if (!$onehot(ifc.req_ready) || busy) proto_viol++;
          for (int i = 0; i < 4; i++)
            if (hs_pend[i]) acc_q.push_back(i);
        end
        if (busy && !prev_busy) begin
          if (have_fall) gap_q.push_back(cyc - fall_cyc);
          rise_cyc = cyc;
        end
        if (!busy && prev_busy) begin
          len_q.push_back(cyc - rise_cyc);
          fall_cyc = cyc;
          have_fall = 1'b1;
        end
        if (!in_frame) begin
          if (!tx && prev_tx) begin
            in_frame = 1'b1; st = cyc; j = 1; sh = '0; rose = 1'b0;
          end
        end else begin
          if (!rose && tx && !prev_tx) begin
            low_q.push_back(cyc - st);
            rose = 1'b1;
          end
          if (cyc - st == $rtoi((j + 0.5) * P)) begin
            if (j <= 8) begin
              sh = {tx, sh[7:1]};
            end else begin
              if (!tx) stop_err++;
              rx_q.push_back(sh);
              in_frame = 1'b0;
            end
            j++;
          end
        end
        prev_tx = tx;
        prev_busy = busy;
      end
    end
  end

  task automatic clear_mon();
    acc_q.delete(); rx_q.delete(); gap_q.delete();
    len_q.delete(); low_q.delete();
    rdy_pulses = 0; rdy1_cnt = 0; proto_viol = 0; stop_err = 0;
    have_fall = 1'b0;
  endtask

  // round-robin over the non-empty queues, starting after last grant
  task automatic load_model();
    logic [7:0] mq [4][$];
    int w;
    for (int i = 0; i < 4; i++) mq[i] = qs[i];
    exp_g.delete();
    exp_b.delete();
    do begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && mq[(model_last + k) % 4].size() > 0)
          w = (model_last + k) % 4;
      if (w >= 0) begin
        exp_g.push_back(w);
        exp_b.push_back(mq[w].pop_front());
        model_last = w;
      end
    end while (w >= 0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n, quiet, pend;
    n = 0; quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      pend = 0;
      for (int i = 0; i < 4; i++) pend += qs[i].size();
      if (pend == 0 && !busy && ifc.req_ready == '0 && man_v == '0)
        quiet++;
      else
        quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, need idle", nm, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b need 1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b need 0", busy);
    end
    checks++;
    if (ifc.req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_ready: got %b need 0000", ifc.req_ready);
    end
    checks++;
    if (gid !== 2'd3) begin
      errors++; $display("FAIL reset_gid: got %0d need 3", gid);
    end
    checks++;
    if (tx_f !== 1'b1 || gid_f !== 2'd3) begin
      errors++; $display("FAIL reset_fast: got tx=%b gid=%0d need 1,3", tx_f, gid_f);
    end
    model_last = 3;
  endtask

  task automatic test_rotate();
    logic [7:0] b;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      qs[i].push_back(b);
    end
    load_model();
    wait_done("rotate", 6000);
    checks++;
    if (acc_q.size() != 4 || rx_q.size() != 4) begin
      errors++;
      $display("FAIL rotate_count: got %0d grants %0d bytes need 4", acc_q.size(), rx_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== i) begin
        errors++; $display("FAIL rotate_grant%0d: need %0d", i, i);
      end
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== b) begin
        errors++; $display("FAIL rotate_byte%0d: need %h", i, b);
      end
    end
    checks++;
    if (gap_q.size() != 3) begin
      errors++; $display("FAIL rotate_gaps: got %0d gaps need 3", gap_q.size());
    end
    foreach (gap_q[k]) begin
      checks++;
      if (gap_q[k] != 1) begin
        errors++; $display("FAIL rotate_gap%0d: got %0d need 1", k, gap_q[k]);
      end
    end
    checks++;
    if (proto_viol != 0 || stop_err != 0) begin
      errors++;
      $display("FAIL rotate_proto: got %0d ready %0d stop errs need 0", proto_viol, stop_err);
    end
  endtask

  task automatic test_single();
    clear_mon();
    qs[0].push_back(8'h55);
    load_model();
    wait_done("single", 2000);
    checks++;
    if (acc_q.size() != 1 || acc_q[0] != 0 || rdy_pulses != 1) begin
      errors++;
      $display("FAIL single_grant: got %0d grants %0d pulses need one to 0", acc_q.size(), rdy_pulses);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++; $display("FAIL single_byte: got %0d bytes need 55", rx_q.size());
    end
    checks++;
    if (low_q.size() != 1 || low_q[0] < 104 || low_q[0] > 105) begin
      errors++; $display("FAIL single_start: got %0d need 104..105", low_q.size() ? low_q[0] : -1);
    end
    checks++;
    if (len_q.size() != 1 || len_q[0] < 1040 || len_q[0] > 1044) begin
      errors++; $display("FAIL single_busy: got %0d need 1040..1044", len_q.size() ? len_q[0] : -1);
    end
    checks++;
    if (stop_err != 0 || gid !== 2'd0) begin
      errors++; $display("FAIL single_stop: got %0d errs gid %0d need 0,0", stop_err, gid);
    end
  endtask

  task automatic test_persist();
    clear_mon();
    repeat (3) qs[2].push_back(8'hA5);
    load_model();
    wait_done("persist", 4000);
    checks++;
    if (acc_q.size() != 3) begin
      errors++; $display("FAIL persist_count: got %0d need 3", acc_q.size());
    end
    foreach (acc_q[k]) begin
      checks++;
      if (acc_q[k] != 2 || k >= rx_q.size() || rx_q[k] !== 8'hA5) begin
        errors++; $display("FAIL persist_frame%0d: got grant %0d need 2 with A5", k, acc_q[k]);
      end
    end
    checks++;
    if (gap_q.size() != 2 || gap_q[0] != 1 || gap_q[1] != 1) begin
      errors++; $display("FAIL persist_gap: got %0d gaps need 2 of 1", gap_q.size());
    end
  endtask

  task automatic test_withdraw();
    int n;
    logic [7:0] d;
    clear_mon();
    d = 8'($urandom);
    qs[0].push_back(d);
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    repeat (200) @(posedge clk);
    #1 man_en[1] = 1'b1; man_v[1] = 1'b1; man_d = 8'($urandom);
    repeat ($urandom_range(50, 400)) @(posedge clk);
    #1 man_v[1] = 1'b0;
    wait_done("withdraw", 2000);
    man_en[1] = 1'b0;
    checks++;
    if (rdy1_cnt != 0) begin
      errors++; $display("FAIL withdraw_ready: got %0d ready cycles need 0", rdy1_cnt);
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0] != 0 || rx_q.size() != 1 || rx_q[0] !== d) begin
      errors++; $display("FAIL withdraw_frame: got %0d grants need one byte %h", acc_q.size(), d);
    end
    model_last = 0;
  endtask

  task automatic test_random();
    int tot;
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      tot = 0;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          qs[i].push_back(8'($urandom));
          tot++;
        end
      end
      if (tot == 0) begin
        qs[$urandom_range(0, 3)].push_back(8'($urandom));
        tot = 1;
      end
      load_model();
      wait_done("random", 1100 * tot + 200);
      checks++;
      if (acc_q.size() != exp_g.size() || rx_q.size() != exp_b.size()) begin
        errors++;
        $display("FAIL random%0d_count: got %0d grants %0d bytes need %0d", r, acc_q.size(), rx_q.size(), exp_g.size());
      end
      foreach (exp_g[k]) begin
        checks++;
        if (k >= acc_q.size() || k >= rx_q.size() || acc_q[k] != exp_g[k] || rx_q[k] !== exp_b[k]) begin
          errors++;
          $display("FAIL random%0d_frame%0d: need grant %0d byte %h", r, k, exp_g[k], exp_b[k]);
        end
      end
      foreach (gap_q[k]) begin
        checks++;
        if (gap_q[k] != 1) begin
          errors++; $display("FAIL random%0d_gap%0d: got %0d need 1", r, k, gap_q[k]);
        end
      end
      checks++;
      if (proto_viol != 0 || stop_err != 0) begin
        errors++; $display("FAIL random%0d_proto: got %0d/%0d need 0", r, proto_viol, stop_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, lows, highs;
    clear_mon();
    qs[0].push_back(8'hFF);
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    repeat (5 * 104 + 52) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ifc.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL resetmid_now: got tx=%b busy=%b rdy=%b need 1,0,0", tx, busy, ifc.req_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = 3;
    clear_mon();
    lows = 0; highs = 0;
    repeat (1500) begin
      @(negedge clk);
      if (!tx) lows++;
      if (busy) highs++;
    end
    checks++;
    if (lows != 0 || highs != 0) begin
      errors++; $display("FAIL resetmid_idle: got %0d low %0d busy cycles need 0", lows, highs);
    end
    checks++;
    if (acc_q.size() != 0 || rx_q.size() != 0 || gid !== 2'd3) begin
      errors++; $display("FAIL resetmid_drop: got %0d grants gid %0d need 0,3", acc_q.size(), gid);
    end
  endtask

  task automatic test_fast();
    logic [7:0] d, got;
    logic       ttx [700];
    logic       tb_ [700];
    logic [3:0] rdy;
    int         n, s, lowlen, blen;
    d = 8'($urandom) | 8'h01;
    ifc_f.req_data  = {24'h0, d};
    ifc_f.req_valid = 4'b0001;
    n = 0;
    rdy = '0;
    while (rdy == '0 && n < 20) begin
      @(negedge clk);
      rdy = ifc_f.req_ready;
      n++;
    end
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL fast_ready: got %b need 0001", rdy);
    end
    @(posedge clk);
    #1 ifc_f.req_valid = '0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      ttx[i] = tx_f;
      tb_[i] = busy_f;
    end
    s = -1;
    for (int i = 0; i < 700; i++) if (s < 0 && !ttx[i]) s = i;
    checks++;
    if (s < 0 || s > 100) begin
      errors++; $display("FAIL fast_start: got %0d need frame start", s);
      s = 0;
    end
    lowlen = 0;
    while (s + lowlen < 699 && !ttx[s + lowlen]) lowlen++;
    blen = 0;
    for (int i = 0; i < 700; i++) if (tb_[i]) blen++;
    for (int b = 0; b < 8; b++) got[b] = ttx[s + 24 + 48 * (b + 1)];
    checks++;
    if (lowlen < 47 || lowlen > 49) begin
      errors++; $display("FAIL fast_bit: got %0d need 47..49", lowlen);
    end
    checks++;
    if (blen < 478 || blen > 482) begin
      errors++; $display("FAIL fast_frame: got %0d need 478..482", blen);
    end
    checks++;
    if (got !== d || ttx[s + 24 + 48 * 9] !== 1'b1) begin
      errors++; $display("FAIL fast_byte: got %h need %h with stop", got, d);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_single();
    test_persist();
    test_withdraw();
    test_random();
    test_reset_mid();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
